hazard_interlock: RTL and testbench

- Parametrised RAW-hazard interlock between instruction fetch and decode/execute.
- Tracks destination registers of the last WB_DIST-1 issued instructions in a history shift register.
- Inserts NOP bubbles until every source operand of the pending instruction is no longer in flight.
- Uses valid/ready handshakes on both sides, supports flush, and keeps a saturating stall counter.

---
 rtl/hazard_interlock.sv | 125 ++++++++++++
 tb/tb_hazard_interlock.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_interlock.sv
// RAW-hazard interlock between fetch and decode/execute. A one-entry holding
// register waits while any of its source registers is still being written back.
module hazard_interlock #(
   parameter int INSTR_W     = 16,
   parameter int OPC_W       = 4,
   parameter int REG_W       = 4,
   parameter int WB_DIST     = 4,
   parameter int ZERO_REG_EN = 1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [INSTR_W-1:0]     in_instr,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [INSTR_W-1:0]     out_instr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   hazard,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam int HIST_N  = WB_DIST - 1;
   localparam int RD_LSB  = INSTR_W - OPC_W - REG_W;
   localparam int RS1_LSB = RD_LSB - REG_W;
   localparam int RS2_LSB = RS1_LSB - REG_W;

   logic               pend_valid;
   logic [INSTR_W-1:0] pend_instr;
   logic               hist_v  [HIST_N];
   logic [REG_W-1:0]   hist_rd [HIST_N];

   logic [OPC_W-1:0] pend_op;
   logic [REG_W-1:0] pend_rd;
   logic [REG_W-1:0] pend_rs1;
   logic [REG_W-1:0] pend_rs2;
   logic             reads_rs1;
   logic             reads_rs2;
   logic             hazard_match;
   logic             issue;
   logic             accept;

   assign pend_op  = pend_instr[INSTR_W-1 -: OPC_W];
   assign pend_rd  = pend_instr[RD_LSB +: REG_W];
   assign pend_rs1 = pend_instr[RS1_LSB +: REG_W];
   assign pend_rs2 = pend_instr[RS2_LSB +: REG_W];

   // Immediate-form opcodes (MSB set) reuse the rs2 field, so it is not a source
   assign reads_rs1 = (pend_op != '0) &&
                      !((ZERO_REG_EN != 0) && (pend_rs1 == '0));
   assign reads_rs2 = (pend_op != '0) && !pend_op[OPC_W-1] &&
                      !((ZERO_REG_EN != 0) && (pend_rs2 == '0));

   always_comb begin
      hazard_match = 1'b0;
      for (int i = 0; i < HIST_N; i++) begin
         if (hist_v[i] && ((reads_rs1 && (hist_rd[i] == pend_rs1)) ||
                           (reads_rs2 && (hist_rd[i] == pend_rs2))))
            hazard_match = 1'b1;
      end
   end

   assign hazard   = pend_valid && hazard_match;
   assign issue    = out_ready && pend_valid && !hazard;
   assign in_ready = !flush && (!pend_valid || (out_ready && !hazard));
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_instr <= '0;
      end else if (flush) begin
         pend_valid <= 1'b0;
      end else if (accept) begin
         pend_valid <= 1'b1;
         pend_instr <= in_instr;
      end else if (issue) begin
         pend_valid <= 1'b0;
      end
   end

   // The history shifts once per advance; bubbles push an invalid entry so an
   // in-flight write ages out after exactly WB_DIST-1 advances.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < HIST_N; i++) begin
            hist_v[i]  <= 1'b0;
            hist_rd[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < HIST_N; i++)
            hist_v[i] <= 1'b0;
      end else if (out_ready) begin
         for (int i = HIST_N - 1; i > 0; i--) begin
            hist_v[i]  <= hist_v[i-1];
            hist_rd[i] <= hist_rd[i-1];
         end
         hist_v[0]  <= issue && (pend_op != '0);
         hist_rd[0] <= pend_rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_instr   <= '0;
         out_valid   <= 1'b0;
         stall_count <= '0;
      end else if (flush) begin
         out_instr <= '0;
         out_valid <= 1'b0;
      end else if (out_ready) begin
         if (issue) begin
            out_instr <= pend_instr;
            out_valid <= 1'b1;
         end else begin
            out_instr <= '0;
            out_valid <= 1'b0;
            if (hazard && (stall_count != '1))
               stall_count <= stall_count + STALL_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_interlock.sv
// Self-checking bench for hazard_interlock: directed scenarios plus random
// traffic, compared each cycle against a readiness-time reference model.
module tb_hazard_interlock;

   localparam int WB = 4;

   logic        clock = 1'b0;
   logic        rst;
   logic        flush;
   logic [15:0] inInstr;
   logic        inValid;
   logic        inReady;
   logic [15:0] outInstr;
   logic        outValid;
   logic        outReady;
   logic        hazard;
   logic [15:0] stallCount;

   int testCount = 0;
   int failCount = 0;

   // Reference model: each register records the advance index from which it
   // becomes readable; an instruction may issue once every source is readable.
   int          readyAt [16];
   int          mAdv;
   logic        mPendV;
   logic [15:0] mPendI;
   logic [15:0] mOutI;
   logic        mOutV;
   logic [15:0] mStall;

   int validRun;
   int maxValidRun;
   int validSeen;

   hazard_interlock #(
      .INSTR_W(16), .OPC_W(4), .REG_W(4), .WB_DIST(WB),
      .ZERO_REG_EN(1), .STALL_CNT_W(16)
   ) dut (
      .clk(clock), .rst(rst), .flush(flush),
      .in_instr(inInstr), .in_valid(inValid), .in_ready(inReady),
      .out_instr(outInstr), .out_valid(outValid), .out_ready(outReady),
      .hazard(hazard), .stall_count(stallCount)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic modelHazard(input logic [15:0] ins);
      logic [3:0] op;
      logic [3:0] s1;
      logic [3:0] s2;
      op = ins[15:12];
      s1 = ins[7:4];
      s2 = ins[3:0];
      if (op == 4'd0) return 1'b0;
      if (s1 != 4'd0 && readyAt[s1] > mAdv) return 1'b1;
      if (!op[3] && s2 != 4'd0 && readyAt[s2] > mAdv) return 1'b1;
      return 1'b0;
   endfunction

   task automatic modelReset();
      for (int r = 0; r < 16; r++) readyAt[r] = 0;
      mAdv = 0; mPendV = 0; mPendI = '0; mOutI = '0; mOutV = 0; mStall = '0;
      validRun = 0; maxValidRun = 0; validSeen = 0;
   endtask

   // One clock cycle: drive inputs, compare outputs against the model, clock, update the model
   task automatic applyStimulus(input logic [15:0] ins, input logic iv, input logic ordy,
                                input logic fl, output logic accepted);
      logic mHaz;
      logic mInRdy;
      logic consume;
      inInstr = ins; inValid = iv; outReady = ordy; flush = fl;
      #2;
      mHaz   = mPendV && modelHazard(mPendI);
      mInRdy = !fl && (!mPendV || (ordy && !mHaz));
      checkOutput("hazard", hazard, mHaz);
      checkOutput("in_ready", inReady, mInRdy);
      checkOutput("out_valid", outValid, mOutV);
      checkOutput("out_instr", outInstr, mOutI);
      checkOutput("stall_count", stallCount, mStall);
      if (outValid === 1'b1) begin
         validSeen++;
         validRun++;
         if (validRun > maxValidRun) maxValidRun = validRun;
      end else begin
         validRun = 0;
      end
      accepted = iv && mInRdy;
      consume  = ordy && mPendV && !mHaz;
      @(posedge clock);
      if (fl) begin
         mPendV = 0; mOutV = 0; mOutI = '0;
         for (int r = 0; r < 16; r++) readyAt[r] = 0;
      end else begin
         if (ordy) begin
            if (consume) begin
               mOutI = mPendI; mOutV = 1;
               if (mPendI[15:12] != 4'd0) readyAt[mPendI[11:8]] = mAdv + WB;
            end else begin
               mOutI = '0; mOutV = 0;
               if (mHaz && mStall != 16'hffff) mStall = mStall + 16'd1;
            end
            mAdv++;
         end
         if (accepted) begin
            mPendV = 1; mPendI = ins;
         end else if (consume) begin
            mPendV = 0;
         end
      end
      #1;
   endtask

   task automatic doReset();
      rst = 1; flush = 0; inValid = 0; outReady = 1; inInstr = '0;
      #2;
      checkOutput("rst_in_ready", inReady, 1);
      checkOutput("rst_hazard", hazard, 0);
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_stall", stallCount, 0);
      @(posedge clock);
      #1 rst = 0;
      modelReset();
   endtask

   task automatic feed(input logic [15:0] ins);
      logic acc;
      logic done;
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         applyStimulus(ins, 1, 1, 0, acc);
         done = acc;
      end
      if (!done) checkOutput("feed_timeout", 0, 1);
   endtask

   task automatic drain(input int n);
      logic acc;
      for (int k = 0; k < n; k++) applyStimulus('0, 0, 1, 0, acc);
   endtask

   initial begin
      logic acc;
      logic [15:0] r;
      rst = 1; flush = 0; inValid = 0; outReady = 1; inInstr = '0;
      modelReset();
      #3;
      doReset();

      // Back-to-back dependency: three bubbles
      feed(16'h1123); feed(16'h2415); drain(6);
      checkOutput("b2b_stall", stallCount, 3);

      // Distance two gives two bubbles, distance four none
      doReset();
      feed(16'h1123); feed(16'h2456); feed(16'h3517); drain(6);
      checkOutput("dist2_stall", stallCount, 2);
      doReset();
      feed(16'h1123); feed(16'h2456); feed(16'h3678); feed(16'h4abc); feed(16'h5519); drain(4);
      checkOutput("dist4_stall", stallCount, 0);

      // Immediate form and zero register
      doReset();
      feed(16'h1123); feed(16'h9411); drain(6);
      checkOutput("imm_stall", stallCount, 3);
      doReset();
      feed(16'h1023); feed(16'h2400); drain(3);
      checkOutput("zero_reg_stall", stallCount, 0);

      // Backpressure during the second bubble
      doReset();
      feed(16'h1123); feed(16'h2415);
      applyStimulus('0, 0, 1, 0, acc);
      applyStimulus('0, 0, 1, 0, acc);
      for (int k = 0; k < 5; k++) applyStimulus('0, 0, 0, 0, acc);
      checkOutput("bp_frozen_stall", stallCount, 2);
      checkOutput("bp_frozen_valid", outValid, 0);
      drain(4);
      checkOutput("bp_final_stall", stallCount, 3);

      // Flush mid-stall; the re-fed instruction issues without a bubble
      doReset();
      feed(16'h1123); feed(16'h2415);
      applyStimulus('0, 0, 1, 0, acc);
      applyStimulus('0, 0, 1, 1, acc);
      checkOutput("flush_valid", outValid, 0);
      feed(16'h2415); drain(3);
      checkOutput("flush_stall", stallCount, 1);

      // Asynchronous reset mid-stall
      doReset();
      feed(16'h1123); feed(16'h2415);
      applyStimulus('0, 0, 1, 0, acc);
      inValid = 0;
      #2 rst = 1;
      #1;
      checkOutput("arst_out_valid", outValid, 0);
      checkOutput("arst_out_instr", outInstr, 0);
      checkOutput("arst_stall", stallCount, 0);
      checkOutput("arst_in_ready", inReady, 1);
      checkOutput("arst_hazard", hazard, 0);
      @(posedge clock);
      #1 rst = 0;
      modelReset();

      // Throughput with independent instructions
      for (int i = 1; i <= 8; i++) begin
         r = 16'h1000 | 16'(i << 8);
         feed(r);
      end
      drain(3);
      checkOutput("tput_valid_count", validSeen, 8);
      checkOutput("tput_max_run", maxValidRun, 8);
      checkOutput("tput_stall", stallCount, 0);

      // Random traffic over a small register set to provoke frequent hazards
      doReset();
      for (int k = 0; k < 1500; k++) begin
         r[15:12] = 4'($urandom_range(0, 15));
         r[11:8]  = 4'($urandom_range(0, 3));
         r[7:4]   = 4'($urandom_range(0, 3));
         r[3:0]   = 4'($urandom_range(0, 3));
         applyStimulus(r, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                       $urandom_range(0, 49) == 0, acc);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
